// File: rtl/semaforo_phase_scheduler.sv
// Two-road intersection phase sequencer with latched pedestrian requests and a WALK phase.
// Optional night blink mode is compiled in with `define SEMAFORO_NIGHT_EN (adds input noche).
module semaforo_phase_scheduler #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned T_GREEN_MIN = 6,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_WALK      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic       paso_a,
  input  logic       paso_b,
`ifdef SEMAFORO_NIGHT_EN
  input  logic       noche,
`endif
  output logic       va,
  output logic       aa,
  output logic       ra,
  output logic       vb,
  output logic       ab,
  output logic       rb,
  output logic       walk_a,
  output logic       walk_b,
  output logic [3:0] numero,
  output logic [2:0] phase
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [3:0] TG = 4'(T_GREEN_MIN);
  localparam logic [3:0] TY = 4'(T_YELLOW);
  localparam logic [3:0] TR = 4'(T_ALLRED);
  localparam logic [3:0] TW = 4'(T_WALK);

  typedef enum logic [2:0] {
    GREEN_A   = 3'd0,
    YELLOW_A  = 3'd1,
    ALLRED_AB = 3'd2,
    GREEN_B   = 3'd3,
    YELLOW_B  = 3'd4,
    ALLRED_BA = 3'd5,
    WALK      = 3'd6
`ifdef SEMAFORO_NIGHT_EN
    , NIGHT   = 3'd7
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    numero_q, numero_d;
  logic          nxt_b_q, nxt_b_d;
  logic [1:0]    ped_q, ped_d;
  logic [1:0]    walk_q, walk_d;
  logic [5:0]    lamp_q, lamp_d;
  logic [PW-1:0] pre_q;
  logic          tick;
  logic          last;
  logic [3:0]    dec;
  logic [1:0]    ped_in;

  assign tick   = enable && (pre_q == '0);
  assign last   = (numero_q <= 4'd1);
  assign dec    = (numero_q == '0) ? '0 : numero_q - 4'd1;
  // A press in the same clk as WALK entry must land in that WALK.
  assign ped_in = ped_q | {paso_b, paso_a};

`ifdef SEMAFORO_NIGHT_EN
  logic noche_m, noche_s;
  logic blink_q, blink_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      noche_m <= 1'b0;
      noche_s <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      noche_m <= noche;
      noche_s <= noche_m;
      blink_q <= blink_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= PRE_TOP;
    end else if (enable) begin
      pre_q <= (pre_q == '0) ? PRE_TOP : pre_q - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    numero_d = numero_q;
    nxt_b_d  = nxt_b_q;
    ped_d    = ped_in;
    walk_d   = walk_q;
    if (tick) begin
      numero_d = dec;
      case (state_q)
        GREEN_A:   if (last && (sensor_b || ped_q != '0)) begin
                     state_d = YELLOW_A;  numero_d = TY;
                   end
        YELLOW_A:  if (last) begin state_d = ALLRED_AB; numero_d = TR; end
        ALLRED_AB: if (last) begin
                     if (ped_in != '0) begin
                       state_d = WALK; numero_d = TW; nxt_b_d = 1'b1;
                     end else begin
                       state_d = GREEN_B; numero_d = TG;
                     end
                   end
        GREEN_B:   if (last && (sensor_a || ped_q != '0)) begin
                     state_d = YELLOW_B;  numero_d = TY;
                   end
        YELLOW_B:  if (last) begin state_d = ALLRED_BA; numero_d = TR; end
        ALLRED_BA: if (last) begin
                     if (ped_in != '0) begin
                       state_d = WALK; numero_d = TW; nxt_b_d = 1'b0;
                     end else begin
                       state_d = GREEN_A; numero_d = TG;
                     end
                   end
        WALK:      if (last) begin
                     state_d  = nxt_b_q ? GREEN_B : GREEN_A;
                     numero_d = TG;
                   end
        default:   ;
      endcase
    end

`ifdef SEMAFORO_NIGHT_EN
    blink_d = blink_q;
    if (noche_s) begin
      state_d  = NIGHT;
      numero_d = '0;
      ped_d    = '0;
      nxt_b_d  = 1'b0;
      blink_d  = (state_q != NIGHT) ? 1'b1 : (tick ? ~blink_q : blink_q);
    end else if (state_q == NIGHT) begin
      state_d  = ALLRED_BA;
      numero_d = TR;
    end
`endif

    if (state_d == WALK && state_q != WALK) begin
      walk_d = ped_in;
      ped_d  = '0;
    end else if (state_d != WALK) begin
      walk_d = '0;
    end

    // Lamps are decoded from the next state so the registered outputs track the phase register.
    lamp_d = {state_d == GREEN_A, state_d == YELLOW_A,
              !(state_d == GREEN_A || state_d == YELLOW_A),
              state_d == GREEN_B, state_d == YELLOW_B,
              !(state_d == GREEN_B || state_d == YELLOW_B)};
`ifdef SEMAFORO_NIGHT_EN
    if (state_d == NIGHT) lamp_d = {1'b0, blink_d, 1'b0, 1'b0, blink_d, 1'b0};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ALLRED_BA;
      numero_q <= TR;
      nxt_b_q  <= 1'b0;
      ped_q    <= '0;
      walk_q   <= '0;
      lamp_q   <= 6'b001001;
    end else begin
      state_q  <= state_d;
      numero_q <= numero_d;
      nxt_b_q  <= nxt_b_d;
      ped_q    <= ped_d;
      walk_q   <= walk_d;
      lamp_q   <= lamp_d;
    end
  end

  assign {va, aa, ra, vb, ab, rb} = lamp_q;
  assign walk_a = walk_q[0];
  assign walk_b = walk_q[1];
  assign numero = numero_q;
  assign phase  = state_q;

endmodule

// File: tb/tb_semaforo_phase_scheduler.sv
// Self-checking bench for semaforo_phase_scheduler: phase-trace table, directed corner sequences,
// and randomized stimulus against a behavioural model of the phase rules.
module tb_semaforo_phase_scheduler;
  localparam int TD = 4;
  localparam int TGM = 6, TYL = 3, TAR = 1, TWK = 7;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic sensor_a = 1'b0, sensor_b = 1'b0, paso_a = 1'b0, paso_b = 1'b0;
  logic va, aa, ra, vb, ab, rb, walk_a, walk_b;
  logic [3:0] numero;
  logic [2:0] phase;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  semaforo_phase_scheduler #(
    .TICK_DIV(TD), .T_GREEN_MIN(TGM), .T_YELLOW(TYL), .T_ALLRED(TAR), .T_WALK(TWK)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sensor_a(sensor_a), .sensor_b(sensor_b), .paso_a(paso_a), .paso_b(paso_b),
    .va(va), .aa(aa), .ra(ra), .vb(vb), .ab(ab), .rb(rb),
    .walk_a(walk_a), .walk_b(walk_b), .numero(numero), .phase(phase)
  );

  // Behavioural model: phase number, ticks left, pending buttons, WALK contents
  int       m_ph, m_rem, m_pre;
  bit [1:0] m_pend, m_walk;
  bit       m_nb;
  int       dur[7] = '{TGM, TYL, TAR, TGM, TYL, TAR, TWK};

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_ph = 5; m_rem = TAR; m_pre = TD - 1; m_pend = '0; m_walk = '0; m_nb = 1'b0;
  endtask

  task automatic model_clk();
    bit [1:0] por;
    bit       tick;
    int       nxt;
    por = m_pend | {paso_b, paso_a};
    nxt = m_ph;
    if (enable) begin
      tick  = (m_pre == 0);
      m_pre = tick ? TD - 1 : m_pre - 1;
      if (tick) begin
        case (m_ph)
          0: if (m_rem <= 1 && (sensor_b || m_pend != 0)) nxt = 1;
          3: if (m_rem <= 1 && (sensor_a || m_pend != 0)) nxt = 4;
          2: if (m_rem <= 1) nxt = (por != 0) ? 6 : 3;
          5: if (m_rem <= 1) nxt = (por != 0) ? 6 : 0;
          6: if (m_rem <= 1) nxt = m_nb ? 3 : 0;
          default: if (m_rem <= 1) nxt = m_ph + 1;
        endcase
        if (nxt != m_ph) m_rem = dur[nxt];
        else if (m_rem > 0) m_rem--;
      end
    end
    if (nxt == 6 && m_ph != 6) begin
      m_nb = (m_ph == 2); m_walk = por; m_pend = '0;
    end else begin
      m_pend = por;
      if (nxt != 6) m_walk = '0;
    end
    m_ph = nxt;
  endtask

  task automatic compare();
    logic [7:0] exp_l;
    bit inv;
    exp_l = {m_ph == 0, m_ph == 1, !(m_ph == 0 || m_ph == 1),
             m_ph == 3, m_ph == 4, !(m_ph == 3 || m_ph == 4),
             m_ph == 6 && m_walk[1] == 1'b0 && m_walk[0], 1'b0};
    exp_l[1] = (m_ph == 6) && m_walk[1];
    exp_l[0] = 1'b0;
    exp_l = {exp_l[7:2], (m_ph == 6) && m_walk[0], (m_ph == 6) && m_walk[1]};
    chk("lamps", {va, aa, ra, vb, ab, rb, walk_a, walk_b}, exp_l);
    chk("numero", numero, m_rem);
    chk("phase", phase, m_ph);
    inv = !(va & vb) && !((va | aa) & (vb | ab)) && !((walk_a | walk_b) & (va | aa | vb | ab))
          && $onehot({va, aa, ra}) && $onehot({vb, ab, rb});
    chk("invariant", inv, 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("reset_lamps", {va, aa, ra, vb, ab, rb, walk_a, walk_b}, 8'b00100100);
    chk("reset_numero", numero, TAR);
    chk("reset_phase", phase, 5);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic wait_phase(input int p, input int bound, input string name);
    int n = 0;
    while (phase != 3'(p) && n < bound) begin
      step();
      n++;
    end
    chk(name, phase, p);
  endtask

  typedef struct {
    logic       sb;
    int         ph;
    int         num;
    int         cycles;
    logic [7:0] lamps;
  } vec_t;
  vec_t tab[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int wl;
    bit saw_b;
    logic [2:0] ph0;
    logic [3:0] n0;

    // Test 1: phase trace after reset with sensor_b held
    tab[0]  = '{1'b1, 5, 1, 3, 8'b00100100};
    tab[1]  = '{1'b1, 0, 6, 4, 8'b10000100};
    tab[2]  = '{1'b1, 0, 5, 4, 8'b10000100};
    tab[3]  = '{1'b1, 0, 4, 4, 8'b10000100};
    tab[4]  = '{1'b1, 0, 3, 4, 8'b10000100};
    tab[5]  = '{1'b1, 0, 2, 4, 8'b10000100};
    tab[6]  = '{1'b1, 0, 1, 4, 8'b10000100};
    tab[7]  = '{1'b1, 1, 3, 4, 8'b01000100};
    tab[8]  = '{1'b1, 1, 2, 4, 8'b01000100};
    tab[9]  = '{1'b1, 1, 1, 4, 8'b01000100};
    tab[10] = '{1'b1, 2, 1, 4, 8'b00100100};
    tab[11] = '{1'b1, 3, 6, 4, 8'b00110000};
    #1;
    do_reset();
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < tab[r].cycles; c++) begin
        sensor_b = tab[r].sb;
        step();
        chk("t1_phase", phase, tab[r].ph);
        chk("t1_numero", numero, tab[r].num);
        chk("t1_lamps", {va, aa, ra, vb, ab, rb, walk_a, walk_b}, tab[r].lamps);
      end
    end

    // Test 2: no demand, green holds at numero 0; demand then leaves within one tick
    sensor_b = 1'b0;
    do_reset();
    wait_phase(0, 10, "t2_green_a");
    repeat (TGM * TD + 20 * TD) step();
    chk("t2_hold_phase", phase, 0);
    chk("t2_hold_numero", numero, 0);
    sensor_b = 1'b1;
    wait_phase(1, TD, "t2_yellow_on_demand");
    sensor_b = 1'b0;

    // Test 3/4: ped A during GREEN_A, ped B during the resulting WALK
    do_reset();
    wait_phase(0, 10, "t3_green_a");
    paso_a = 1'b1;
    step();
    paso_a = 1'b0;
    wait_phase(6, 200, "t3_walk_entry");
    chk("t3_walk_a", walk_a, 1);
    chk("t3_walk_b", walk_b, 0);
    chk("t3_reds", {ra, rb}, 2'b11);
    wl = 1;
    saw_b = 1'b0;
    for (int i = 0; i < 40 && phase == 3'd6; i++) begin
      paso_b = (i == 4);
      step();
      paso_b = 1'b0;
      if (phase == 3'd6) begin
        wl++;
        if (walk_b) saw_b = 1'b1;
      end
    end
    chk("t3_walk_len", wl, TWK * TD);
    chk("t3_then_green_b", phase, 3);
    chk("t4_current_walk_b", saw_b, 0);
    wait_phase(5, 200, "t4_allred_ba");
    wait_phase(6, 20, "t4_second_walk");
    chk("t4_walk_b", walk_b, 1);
    chk("t4_walk_a", walk_a, 0);

    // Test 5: async reset mid-YELLOW_A, then enable low freezes everything
    do_reset();
    sensor_b = 1'b1;
    wait_phase(1, 100, "t5_yellow_a");
    step();
    do_reset();
    sensor_b = 1'b0;
    repeat (6) step();
    enable = 1'b0;
    ph0 = phase;
    n0 = numero;
    repeat (10 * TD) step();
    chk("t5_frozen_phase", phase, ph0);
    chk("t5_frozen_numero", numero, n0);
    enable = 1'b1;

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) sensor_a = ~sensor_a;
      if ($urandom_range(29) == 0) sensor_b = ~sensor_b;
      paso_a = ($urandom_range(59) == 0);
      paso_b = ($urandom_range(59) == 0);
      enable = ($urandom_range(19) != 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
